viterbi_ber_test_ctrl: RTL and testbench
========================================

Name: viterbi_ber_test_ctrl

Overview:
Self-checking bit-error-rate test sequencer for the encoder -> channel -> Viterbi decoder chain. On `start` it does four things:
- generates a PRBS-7 information stream and drives the encoder enable for a programmed bit count;
- owns the channel register and injects periodic symbol-bit errors;
- gates the decoder enable;
- compares decoder output against a latency-matched copy of the sent data.

It replaces ad-hoc error injection in the tx/rx wrapper and reports injected-bit and decoded-error counts.

Parameters:
- LAT, 34, cycles from a cycle with enc_en_o=1 to the cycle its decoded bit is on dec_data_i (includes the chan_out register stage)
- CW, 16, width of num_bits and of both result counters
- PW, 4, width of err_period

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  launch request, sampled only in IDLE
- num_bits  in  CW  information bits to send
- err_period  in  PW  injection period in valid symbols; 0 = no injection
- err_burst  in  PW  consecutive corrupted symbols at the end of each period
- err_mask  in  2  symbol bits XOR-flipped on injected symbols
- enc_en_o  out  1  encoder enable
- enc_data_o  out  1  encoder information bit
- enc_valid_i  in  1  encoder output-valid
- chan_i  in  2  encoder output symbol
- chan_o  out  2  registered, possibly corrupted symbol to decoder
- dec_en_o  out  1  decoder enable, registered copy of enc_valid_i
- dec_data_i  in  1  decoder output bit
- busy  out  1  high outside IDLE
- done  out  1  one-cycle completion pulse
- inj_ct  out  CW  total flipped channel bits, saturating
- err_ct  out  CW  decoded-bit mismatches, saturating

Behaviour:
- Clocking/reset: one clock, `clk`. Reset `rst` is synchronous, active-high, and takes priority over everything.
- Reset values: state=IDLE; all outputs 0; lfsr=7'h7F; phase=0; all counters 0; delay lines cleared.
- Reset mid-operation: all of the above on the next edge. No done pulse. Counts are lost.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE, start=1, num_bits!=0 -> RUN. On that edge: latch num_bits/err_period/err_burst/err_mask; clear inj_ct, err_ct, phase and sent/checked counters; lfsr=7'h7F.
  - IDLE, start=1, num_bits=0 -> DONE. Counts are cleared to 0.
  - RUN: enc_en_o=1, enc_data_o=lfsr[6]. Each cycle lfsr <= {lfsr[5:0], lfsr[6]^lfsr[5]} and sent++. When sent reaches num_bits -> DRAIN, so exactly num_bits cycles of enc_en_o.
  - DRAIN: enc_en_o=0, enc_data_o=0. When checked == num_bits -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- start while busy is ignored; latched config is unaffected.
- Timing: if start is accepted at edge k, enc_en_o is high for cycles k+1 .. k+num_bits. done is high in cycle k+num_bits+LAT+1.
- Channel register, every cycle including IDLE:
  - dec_en_o <= enc_valid_i.
  - chan_o <= chan_i ^ (inj ? mask : 2'b00).
  - inj = enc_valid_i & busy & (period!=0) & (phase >= period - min(burst, period)).
  - err_burst >= err_period corrupts every valid symbol.
- Phase counter: advances only on enc_valid_i & busy. Runs 0..period-1, then wraps to 0.
- inj_ct: += popcount(mask) on each inj cycle, saturating at all-ones.
- Reference path: LAT-deep shift register of {enc_en_o, enc_data_o}. When the delayed enable is 1:
  - checked++;
  - if dec_data_i != delayed data, err_ct++, saturating at 2^CW-1.
- Compare pipeline: advances in all states. Only the delayed enable marks a compare cycle.
- Results: inj_ct and err_ct hold after done until the next accepted start.
- Counter widths: CW-bit unsigned. phase is PW bits. Comparison `phase >= period - burst` is done without underflow (clamp as stated).

Test Plan:
- Clean run: err_period=0, num_bits=100, ideal decoder model. Expect enc_en_o high exactly 100 cycles; done exactly 135 cycles after the start edge; inj_ct=0; err_ct=0; chan_o = chan_i delayed 1 cycle.
- Burst injection: err_period=15 in PW=4 terms (use PW=5, period=16), burst=2, mask=01, num_bits=256, encoder valid every enabled cycle. Expect symbols with phase 14 and 15 corrupted (32 symbols); inj_ct=32; err_ct=0 with the K=3 Viterbi decoder. Repeat with mask=11: inj_ct=64.
- Mismatch/saturation: CW=4, num_bits=12, decoder model inverts output. Expect err_ct=12. Then num_bits=15 inverted: err_ct=15. Then num_bits=15 plus one extra bit sent (config allows max 15 with CW=4) with the counter preset at 15: err_ct holds at 15, no wrap.
- start while busy: second start in RUN -> no restart, counts unchanged, single done pulse. num_bits=0 -> done one cycle after start, counts 0.
- Reset mid-run: rst=1 at sent=50 -> next cycle busy=0, enc_en_o=0, counters 0, no done. Fresh start then behaves as the clean run.
- PRBS check: first 8 enc_data_o bits after start = 1,1,1,1,1,1,1,0. Sequence repeats with period 127.

Source files
------------

// File: rtl/viterbi_ber_test_ctrl_if.sv
// Codec-chain link between the BER test sequencer and the encoder ->
// channel -> Viterbi decoder datapath.
//   enc_en_o    encoder enable            (sequencer -> encoder)
//   enc_data_o  encoder information bit   (sequencer -> encoder)
//   enc_valid_i encoder output-valid      (encoder -> sequencer)
//   chan_i      encoder output symbol     (encoder -> sequencer)
//   chan_o      registered/corrupted symbol (sequencer -> decoder)
//   dec_en_o    decoder enable            (sequencer -> decoder)
//   dec_data_i  decoder output bit        (decoder -> sequencer)
// master = sequencer side, slave = codec chain side.
interface viterbi_ber_test_ctrl_if;
  logic       enc_en_o;
  logic       enc_data_o;
  logic       enc_valid_i;
  logic [1:0] chan_i;
  logic [1:0] chan_o;
  logic       dec_en_o;
  logic       dec_data_i;

  modport master (
    output enc_en_o, enc_data_o, chan_o, dec_en_o,
    input  enc_valid_i, chan_i, dec_data_i
  );

  modport slave (
    input  enc_en_o, enc_data_o, chan_o, dec_en_o,
    output enc_valid_i, chan_i, dec_data_i
  );
endinterface

// File: rtl/viterbi_ber_test_ctrl.sv
// Bit-error-rate test sequencer for the encoder -> channel -> Viterbi chain.
// Sends a PRBS-7 stream for num_bits cycles, owns the channel register and
// flips symbol bits periodically, gates the decoder enable and compares the
// decoded stream against a LAT-deep delayed copy of the sent bits.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               launch request (sampled only when idle)
//   num_bits            information bits to send (0 = immediate done)
//   err_period          injection period in valid symbols, 0 = off
//   err_burst           corrupted symbols at the end of each period
//   err_mask            symbol bits flipped on corrupted symbols
//   chain               codec-chain link (master modport)
//   busy, done          status: not idle / one-cycle completion pulse
//   inj_ct, err_ct      flipped channel bits / decoded mismatches (saturating)
module viterbi_ber_test_ctrl #(
  parameter int LAT = 34,
  parameter int CW  = 16,
  parameter int PW  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] num_bits,
  input  logic [PW-1:0] err_period,
  input  logic [PW-1:0] err_burst,
  input  logic [1:0]    err_mask,
  viterbi_ber_test_ctrl_if.master chain,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] inj_ct,
  output logic [CW-1:0] err_ct
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] nb_q, sent, checked;
  logic [PW-1:0] period_q, burst_q, phase, burst_eff, inj_thr;
  logic [1:0]    mask_q, mask_pop;
  logic [6:0]    lfsr;
  logic [LAT-1:0] ref_en_p, ref_dat_p;
  logic          accept, inj, cmp_en, mism, last_sent, last_chk;

  function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a,
                                            input logic [1:0]    b);
    logic [CW:0] s;
    s = {1'b0, a} + {{(CW-1){1'b0}}, b};
    return s[CW] ? {CW{1'b1}} : s[CW-1:0];
  endfunction

  assign busy             = (state != IDLE);
  assign done             = (state == DONE);
  assign chain.enc_en_o   = (state == RUN);
  assign chain.enc_data_o = (state == RUN) & lfsr[6];
  assign accept           = (state == IDLE) & start;
  assign cmp_en           = ref_en_p[LAT-1];
  assign mism             = cmp_en & (chain.dec_data_i != ref_dat_p[LAT-1]);
  assign last_sent        = (sent == nb_q - CW'(1));
  // The final compare edge is the one that moves DRAIN to DONE, so done
  // lands exactly LAT+1 cycles after the last enabled cycle.
  assign last_chk         = cmp_en & (checked == nb_q - CW'(1));

  // Burst is clamped to the period so the threshold never underflows;
  // burst >= period therefore corrupts every valid symbol.
  always_comb begin
    burst_eff = (burst_q > period_q) ? period_q : burst_q;
    inj_thr   = period_q - burst_eff;
    inj       = chain.enc_valid_i & busy & (period_q != '0) & (phase >= inj_thr);
    mask_pop  = {1'b0, mask_q[0]} + {1'b0, mask_q[1]};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (num_bits != '0) ? RUN : DONE;
      RUN:     if (last_sent) state_nxt = DRAIN;
      DRAIN:   if (last_chk) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      nb_q     <= '0;
      period_q <= '0;
      burst_q  <= '0;
      mask_q   <= '0;
      lfsr     <= 7'h7F;
      phase    <= '0;
      sent     <= '0;
      checked  <= '0;
      inj_ct   <= '0;
      err_ct   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        nb_q     <= num_bits;
        period_q <= err_period;
        burst_q  <= err_burst;
        mask_q   <= err_mask;
        lfsr     <= 7'h7F;
        phase    <= '0;
        sent     <= '0;
        checked  <= '0;
        inj_ct   <= '0;
        err_ct   <= '0;
      end else begin
        if (state == RUN) begin
          lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
          sent <= sent + CW'(1);
        end
        if (chain.enc_valid_i & busy)
          phase <= ((period_q == '0) || (phase == period_q - PW'(1))) ? '0 : phase + PW'(1);
        if (inj)
          inj_ct <= sat_add(inj_ct, mask_pop);
        if (cmp_en) begin
          checked <= checked + CW'(1);
          if (mism) err_ct <= sat_add(err_ct, 2'd1);
        end
      end
    end
  end

  // ---- channel register stage / reference delay line (runs in all states)
  always_ff @(posedge clk) begin
    if (rst) begin
      chain.chan_o   <= '0;
      chain.dec_en_o <= 1'b0;
      ref_en_p       <= '0;
      ref_dat_p      <= '0;
    end else begin
      chain.chan_o   <= chain.chan_i ^ (inj ? mask_q : 2'b00);
      chain.dec_en_o <= chain.enc_valid_i;
      ref_en_p       <= {ref_en_p[LAT-2:0], chain.enc_en_o};
      ref_dat_p      <= {ref_dat_p[LAT-2:0], chain.enc_data_o};
    end
  end

endmodule

// File: tb/tb_viterbi_ber_test_ctrl.sv
// Directed bench for viterbi_ber_test_ctrl. A main instance (CW=16, PW=5)
// covers timing, PRBS, injection and control; a narrow instance (CW=4,
// PW=4) sharing the same stimulus covers counter saturation.
module tb_viterbi_ber_test_ctrl;
  localparam int LAT = 34;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] num_bits = '0;
  logic [4:0]  err_period = '0;
  logic [4:0]  err_burst = '0;
  logic [1:0]  err_mask = '0;
  logic        dec_inv = 1'b0;

  logic        busy, done;
  logic [15:0] inj_ct, err_ct;
  logic        s_busy, s_done;
  logic [3:0]  s_inj, s_err;

  int n_checks = 0;
  int n_fail = 0;

  viterbi_ber_test_ctrl_if bus ();
  viterbi_ber_test_ctrl_if sbus ();

  viterbi_ber_test_ctrl #(.LAT(LAT), .CW(16), .PW(5)) u_dut (
    .clk(clk), .rst(rst), .start(start), .num_bits(num_bits),
    .err_period(err_period), .err_burst(err_burst), .err_mask(err_mask),
    .chain(bus), .busy(busy), .done(done), .inj_ct(inj_ct), .err_ct(err_ct)
  );

  viterbi_ber_test_ctrl #(.LAT(LAT), .CW(4), .PW(4)) u_sat (
    .clk(clk), .rst(rst), .start(start), .num_bits(num_bits[3:0]),
    .err_period(err_period[3:0]), .err_burst(err_burst[3:0]), .err_mask(err_mask),
    .chain(sbus), .busy(s_busy), .done(s_done), .inj_ct(s_inj), .err_ct(s_err)
  );

  always #5 clk = ~clk;

  // Chain model: encoder valid follows enable, symbols are a free-running
  // pattern, decoder is an ideal LAT-cycle delay (optionally inverted).
  logic [1:0]     cyc = '0;
  logic [LAT-1:0] dpipe = '0;
  logic [LAT-1:0] sdpipe = '0;
  always @(posedge clk) begin
    cyc    <= cyc + 2'd1;
    dpipe  <= {dpipe[LAT-2:0], bus.enc_data_o};
    sdpipe <= {sdpipe[LAT-2:0], sbus.enc_data_o};
  end
  assign bus.enc_valid_i  = bus.enc_en_o;
  assign bus.chan_i       = cyc;
  assign bus.dec_data_i   = dpipe[LAT-1] ^ dec_inv;
  assign sbus.enc_valid_i = sbus.enc_en_o;
  assign sbus.chan_i      = cyc;
  assign sbus.dec_data_i  = sdpipe[LAT-1] ^ dec_inv;

  // Channel monitor on the main instance.
  logic [1:0] chan_prev = '0;
  logic       vprev = 1'b0, vraw_prev = 1'b0, mon_clr = 1'b0;
  int sym_idx = 0, idx_prev = 0;
  int flip_bits = 0, bad_flips = 0, den_err = 0;
  always @(posedge clk) begin
    chan_prev <= bus.chan_i;
    vraw_prev <= bus.enc_valid_i;
    vprev     <= bus.enc_valid_i & busy;
    idx_prev  <= sym_idx;
    if (!busy) sym_idx <= 0;
    else if (bus.enc_valid_i) sym_idx <= sym_idx + 1;
  end
  always @(negedge clk) begin
    if (mon_clr) begin
      flip_bits <= 0;
      bad_flips <= 0;
      den_err   <= 0;
    end else begin
      if (bus.chan_o != chan_prev) begin
        flip_bits <= flip_bits + $countones(bus.chan_o ^ chan_prev);
        if (!vprev || (idx_prev % 16) < 14) bad_flips <= bad_flips + 1;
      end
      if (bus.dec_en_o != vraw_prev) den_err <= den_err + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  int   r_done_at, r_en, r_done_cnt, r_sdone_cnt;
  bit   r_tmo;
  logic r_bits [0:299];

  // One transaction: start accepted at edge k; cycle n is cycle k+n.
  task automatic run(input int nb, input int per, input int bur, input int msk,
                     input bit inv, input int restart_at);
    int n;
    @(posedge clk); #1;
    num_bits = nb[15:0]; err_period = per[4:0]; err_burst = bur[4:0];
    err_mask = msk[1:0]; dec_inv = inv; start = 1'b1; mon_clr = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mon_clr = 1'b0;
    r_done_at = 0; r_en = 0; r_done_cnt = 0; r_sdone_cnt = 0; r_tmo = 0; n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (bus.enc_en_o) begin
        if (r_en < 300) r_bits[r_en] = bus.enc_data_o;
        r_en++;
      end
      if (done) begin
        r_done_cnt++;
        if (r_done_at == 0) r_done_at = n;
      end
      if (s_done) r_sdone_cnt++;
      if (n == restart_at) begin
        start = 1'b1;
        num_bits = 16'd5;
      end else if (n == restart_at + 1) begin
        start = 1'b0;
      end
      if (r_done_at != 0 && n >= r_done_at + 3) break;
      if (n >= 1000) begin
        r_tmo = 1;
        break;
      end
    end
    check_eq("timeout", r_tmo, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] f8;
    int pm, n, en, dc;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ctl", {busy, done, bus.enc_en_o, bus.enc_data_o, bus.dec_en_o}, 0);
    check_eq("rst_chan", bus.chan_o, 0);
    check_eq("rst_inj", inj_ct, 0);
    check_eq("rst_err", err_ct, 0);
    rst = 1'b0;

    // Clean run
    run(100, 0, 0, 0, 0, -1);
    check_eq("clean_done_at", r_done_at, 135);
    check_eq("clean_en", r_en, 100);
    check_eq("clean_done_cnt", r_done_cnt, 1);
    check_eq("clean_inj", inj_ct, 0);
    check_eq("clean_err", err_ct, 0);
    check_eq("clean_chan", flip_bits, 0);
    check_eq("clean_dec_en", den_err, 0);
    for (int i = 0; i < 8; i++) f8[7-i] = r_bits[i];
    check_eq("prbs_first8", f8, 8'hFE);

    // Burst injection, period 16, burst 2, mask 01
    run(256, 16, 2, 1, 0, -1);
    check_eq("b1_done_at", r_done_at, 291);
    check_eq("b1_inj", inj_ct, 32);
    check_eq("b1_flips", flip_bits, 32);
    check_eq("b1_bad_phase", bad_flips, 0);
    check_eq("b1_err", err_ct, 0);
    pm = 0;
    for (int i = 0; i < 129; i++) if (r_bits[i] !== r_bits[i+127]) pm++;
    check_eq("prbs_period", pm, 0);

    // Same with mask 11
    run(256, 16, 2, 3, 0, -1);
    check_eq("b3_inj", inj_ct, 64);
    check_eq("b3_flips", flip_bits, 64);
    check_eq("b3_bad_phase", bad_flips, 0);

    // Start while busy, inverted decoder, period 4 burst 1
    run(100, 4, 1, 1, 1, 20);
    check_eq("busy_done_at", r_done_at, 135);
    check_eq("busy_done_cnt", r_done_cnt, 1);
    check_eq("busy_en", r_en, 100);
    check_eq("busy_err", err_ct, 100);
    check_eq("busy_inj", inj_ct, 25);
    repeat (10) @(negedge clk);
    check_eq("hold_err", err_ct, 100);
    check_eq("hold_inj", inj_ct, 25);

    // num_bits = 0
    run(0, 0, 0, 0, 0, -1);
    check_eq("zero_done_at", r_done_at, 1);
    check_eq("zero_done_cnt", r_done_cnt, 1);
    check_eq("zero_en", r_en, 0);
    check_eq("zero_inj", inj_ct, 0);
    check_eq("zero_err", err_ct, 0);

    // Reset mid-run at sent = 50
    @(posedge clk); #1;
    num_bits = 16'd100; err_period = 5'd4; err_burst = 5'd1; err_mask = 2'b11;
    dec_inv = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0; en = 0;
    while (en < 50 && n < 300) begin
      @(negedge clk);
      n++;
      if (bus.enc_en_o) en++;
    end
    check_eq("mid_reach", en, 50);
    check_eq("mid_pre_inj", inj_ct, 24);
    check_eq("mid_pre_err", err_ct, 15);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_ctl", {busy, done, bus.enc_en_o}, 0);
    check_eq("mid_inj", inj_ct, 0);
    check_eq("mid_err", err_ct, 0);
    rst = 1'b0;
    dc = 0;
    repeat (60) begin
      @(negedge clk);
      if (done) dc++;
    end
    check_eq("mid_no_done", dc, 0);

    run(100, 0, 0, 0, 0, -1);
    check_eq("fresh_done_at", r_done_at, 135);
    check_eq("fresh_en", r_en, 100);
    check_eq("fresh_inj", inj_ct, 0);
    check_eq("fresh_err", err_ct, 0);

    // Narrow counters (CW=4)
    run(12, 0, 0, 0, 1, -1);
    check_eq("sat12_err", s_err, 12);
    check_eq("sat12_done", r_sdone_cnt, 1);
    run(15, 0, 0, 0, 1, -1);
    check_eq("sat15_err", s_err, 15);
    check_eq("sat15_busy", s_busy, 0);
    run(15, 1, 3, 3, 1, -1);
    check_eq("satinj_inj", s_inj, 15);
    check_eq("satinj_err", s_err, 15);
    check_eq("satinj_main_inj", inj_ct, 30);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
